// File: rtl/jtpang_dma_pkg.sv
// jtpang_dma_pkg: shared constants for the Pang object-table DMA.
//   - dma_st_e : sequencer state encoding
//   - DMA_LEN  : default bytes per transfer
//   - DMA_BASE : default first source address
// ST_WAITVB exists only when JTPANG_DMA_VBLSYNC_EN is defined.
package jtpang_dma_pkg;

  localparam int          DMA_LEN  = 512;
  localparam logic [11:0] DMA_BASE = 12'h000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_XFER    = 3'd2,
    ST_LAST    = 3'd3,
    ST_RELEASE = 3'd4
`ifdef JTPANG_DMA_VBLSYNC_EN
    , ST_WAITVB = 3'd5
`endif
  } dma_st_e;

endpackage

// File: rtl/jtpang_dma_edge.sv
// jtpang_dma_edge: rising-edge detector with a one-deep pending latch.
// It runs on every clk, ignoring cen, so short strobes are never missed.
//   clk, rst : clock, async active-high reset
//   din_i    : level input to watch
//   clr_i    : consume the pending request
//   set_o    : single-clk pulse on a 0->1 transition of din_i
//   pend_o   : request latched and not yet consumed
// A new edge wins over a simultaneous clear, so a request arriving
// exactly as the previous one is taken is still kept.
module jtpang_dma_edge (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  input  logic clr_i,
  output logic set_o,
  output logic pend_o
);

  logic din_q, pend_q;

  // din_q resets high so a level already present at reset exit is not
  // taken as a request
  assign set_o  = din_i & ~din_q;
  assign pend_o = pend_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_q  <= 1'b1;
      pend_q <= 1'b0;
    end else begin
      din_q <= din_i;
      if (set_o)      pend_q <= 1'b1;
      else if (clr_i) pend_q <= 1'b0;
    end
  end

endmodule

// File: rtl/jtpang_objdma.sv
// jtpang_objdma: object-table DMA sequencer for the Pang main board.
// A rising edge on dma_go requests the Z80 bus, copies LEN bytes from
// the shared video RAM (BASE onwards) into the non-displayed half of the
// object line buffer, releases the bus and flips the displayed bank.
//   clk, rst, cen : clock, async active-high reset, clock enable
//   dma_go        : request level from I/O decode (rising edge = go)
//   LVBL          : vertical blank, active low
//   busrq_n/busak_n : Z80 bus request / acknowledge
//   src_addr/src_rd/src_din : video RAM read port (data one cen late)
//   buf_addr/buf_dout/buf_we : object buffer write port {wr_bank,index}
//   disp_bank     : bank the renderer reads; writes go to ~disp_bank
//   busy          : request accepted and not yet finished
// Optional feature JTPANG_DMA_VBLSYNC_EN: defer the bank flip to the
// next LVBL falling edge to avoid tearing. Undefined: LVBL is ignored.
module jtpang_objdma
  import jtpang_dma_pkg::*;
#(
  parameter int            AW   = 12,
  parameter int            LEN  = DMA_LEN,
  parameter logic [AW-1:0] BASE = AW'(DMA_BASE)
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          dma_go,
  input  logic          LVBL,
  output logic          busrq_n,
  input  logic          busak_n,
  output logic [AW-1:0] src_addr,
  output logic          src_rd,
  input  logic [7:0]    src_din,
  output logic [9:0]    buf_addr,
  output logic [7:0]    buf_dout,
  output logic          buf_we,
  output logic          disp_bank,
  output logic          busy
);

  localparam logic [8:0] LAST_CNT = 9'(LEN-1);

  dma_st_e       st_q;
  logic [8:0]    cnt_q;
  logic          busrq_q, src_rd_q, buf_we_q, disp_q, busy_q;
  logic [AW-1:0] src_addr_q;
  logic [9:0]    buf_addr_q;
  logic [7:0]    buf_dout_q;
  logic          wr_bank;
  logic          go_pend, pend_clr, unused_go_rise;

  assign wr_bank  = ~disp_q;
  assign pend_clr = cen & (st_q == ST_IDLE) & go_pend;

  jtpang_dma_edge u_go (
    .clk    (clk),
    .rst    (rst),
    .din_i  (dma_go),
    .clr_i  (pend_clr),
    .set_o  (unused_go_rise),
    .pend_o (go_pend)
  );

`ifdef JTPANG_DMA_VBLSYNC_EN
  logic lvbl_q, lvbl_fall;
  // lvbl_q resets low so a low LVBL right after reset is not a fall
  assign lvbl_fall = lvbl_q & ~LVBL;
`else
  logic unused_lvbl;
  assign unused_lvbl = LVBL;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= ST_IDLE;
      cnt_q      <= '0;
      busrq_q    <= 1'b1;
      src_rd_q   <= 1'b0;
      buf_we_q   <= 1'b0;
      disp_q     <= 1'b0;
      busy_q     <= 1'b0;
      src_addr_q <= BASE;
      buf_addr_q <= '0;
      buf_dout_q <= '0;
`ifdef JTPANG_DMA_VBLSYNC_EN
      lvbl_q     <= 1'b0;
`endif
    end else if (cen) begin
`ifdef JTPANG_DMA_VBLSYNC_EN
      lvbl_q <= LVBL;
`endif
      case (st_q)
        ST_IDLE: if (go_pend) begin
          st_q    <= ST_REQ;
          busy_q  <= 1'b1;
          busrq_q <= 1'b0;
        end
        ST_REQ: if (!busak_n) begin
          st_q  <= ST_XFER;
          cnt_q <= '0;
        end
        ST_XFER: begin
          if (busak_n) begin
            // bus taken back: freeze, the byte in flight is dropped
            src_rd_q <= 1'b0;
            buf_we_q <= 1'b0;
          end else if (cnt_q != 9'd0 && !src_rd_q) begin
            // resuming after a freeze: re-read the dropped byte first
            src_rd_q   <= 1'b1;
            src_addr_q <= BASE + AW'(cnt_q - 9'd1);
            buf_we_q   <= 1'b0;
          end else begin
            src_rd_q   <= 1'b1;
            src_addr_q <= BASE + AW'(cnt_q);
            buf_we_q   <= src_rd_q;
            buf_addr_q <= {wr_bank, cnt_q - 9'd1};
            buf_dout_q <= src_din;
            if (cnt_q == LAST_CNT) st_q  <= ST_LAST;
            else                   cnt_q <= cnt_q + 9'd1;
          end
        end
        ST_LAST: begin
          src_rd_q   <= 1'b0;
          buf_we_q   <= 1'b1;
          buf_addr_q <= {wr_bank, LAST_CNT};
          buf_dout_q <= src_din;
          st_q       <= ST_RELEASE;
        end
        ST_RELEASE: begin
          busrq_q  <= 1'b1;
          buf_we_q <= 1'b0;
`ifdef JTPANG_DMA_VBLSYNC_EN
          st_q     <= ST_WAITVB;
`else
          disp_q   <= ~disp_q;
          busy_q   <= 1'b0;
          st_q     <= ST_IDLE;
`endif
        end
`ifdef JTPANG_DMA_VBLSYNC_EN
        ST_WAITVB: if (lvbl_fall) begin
          disp_q <= ~disp_q;
          busy_q <= 1'b0;
          st_q   <= ST_IDLE;
        end
`endif
        default: st_q <= ST_IDLE;
      endcase
    end
  end

  assign busrq_n   = busrq_q;
  assign src_addr  = src_addr_q;
  assign src_rd    = src_rd_q;
  assign buf_addr  = buf_addr_q;
  assign buf_dout  = buf_dout_q;
  assign buf_we    = buf_we_q;
  assign disp_bank = disp_q;
  assign busy      = busy_q;

endmodule

// File: doc/jtpang_objdma.md
Name: jtpang_objdma

Overview:
- Object-table DMA sequencer for the Pang main board.
- A CPU write to I/O port 6 (dma_go) starts it. It requests the Z80 bus, copies the object attribute area byte by byte from the shared video RAM into a double-buffered object line buffer, releases the bus, then flips the displayed buffer bank.
- Sits between jtpang_main (busrq_n/busak_n/dma_go) and the object renderer.

Parameters:
- AW, 12, source address width (matches cpu_addr)
- LEN, 512, bytes per transfer
- BASE, 12'h000, first source address

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- cen  in  1  clock enable; every state advance is gated by cen
- dma_go  in  1  level from I/O decode; rising edge = request
- LVBL  in  1  vertical blank, active low (used only with the optional feature)
- busrq_n  out  1  bus request to the CPU
- busak_n  in  1  bus acknowledge from the CPU
- src_addr  out  AW  source RAM address
- src_rd  out  1  source read strobe
- src_din  in  8  source data; valid one cen after src_rd
- buf_addr  out  10  {wr_bank, byte index[8:0]}
- buf_dout  out  8  data to the object buffer
- buf_we  out  1  object buffer write strobe
- disp_bank  out  1  bank the renderer reads
- busy  out  1  high from the accepted request until RELEASE completes

Behaviour:
- Reset values: busrq_n=1, src_rd=0, buf_we=0, busy=0, disp_bank=0, src_addr=BASE, buf_addr=0, buf_dout=0, pending=0.
- wr_bank is always ~disp_bank.
- Edge detection: dma_go is sampled on every clk, not gated by cen. A 0->1 transition sets pending.
- FSM states: IDLE, REQ, XFER, LAST, RELEASE.
- IDLE: if pending, go to REQ; clear pending; set busy=1; drive busrq_n=0.
- REQ: hold until busak_n=0 is seen on a cen cycle, then go to XFER with cnt=0.
- XFER, per cen:
  - src_rd=1 and src_addr=BASE+cnt.
  - From the second cycle on, buf_we=1 with buf_addr={wr_bank,cnt-1} and buf_dout=src_din.
  - cnt increments each cycle.
  - When cnt reaches LEN-1 after issuing that read, go to LAST.
- XFER throughput: one byte per cen after 1 cen of latency. A full transfer takes LEN+1 cen in XFER plus LAST.
- LAST: src_rd=0, write the final byte at {wr_bank,LEN-1}, go to RELEASE.
- RELEASE: busrq_n=1, buf_we=0, toggle disp_bank, busy=0, go to IDLE.
- buf_we and src_rd are single-cen-wide strobes. Both are 0 outside XFER and LAST.
- The counter is 9 bits wide; LEN must be ≤512. No wrap occurs because the terminal compare happens first.
- A dma_go edge while busy sets pending. Only one pending request is held; extra edges are dropped. After RELEASE, IDLE restarts immediately.
- If busak_n deasserts during XFER, the transfer freezes: no strobes and cnt holds. It resumes when busak_n returns low. busrq_n stays low throughout.
- A dma_go edge and RELEASE in the same cycle: pending is set and the transfer restarts.
- rst mid-transfer: all outputs return to reset values immediately, including busrq_n=1. The partial buffer contents are left as they are. disp_bank is not toggled.

Optional Feature:
- Macro JTPANG_DMA_VBLSYNC_EN.
- Defined: the bank flip in RELEASE is deferred until the next LVBL falling edge. busy stays high until the flip, and new requests stay pending until then. This prevents tearing when DMA finishes mid-frame.
- Undefined: the flip happens immediately in RELEASE and LVBL is ignored.

Decomposition:
- Package jtpang_dma_pkg holds:
  - the state encoding constants (IDLE=0, REQ=1, XFER=2, LAST=3, RELEASE=4, plus WAITVB=5 when the feature is on)
  - the default LEN and BASE values
- The counter/address generator stays inline.
- One sub-module is natural: jtpang_dma_edge, a rising-edge detector with a one-deep pending latch. It exposes set, clear and pending, and is reusable for the vbank and EEPROM strobes.

Test Plan:
- Basic transfer: after reset, pulse dma_go and return busak_n=0 two cen later. Require busrq_n=0 within 1 cen of the edge, 512 buf_we strobes at addresses 0x200..0x3FF with data equal to the source pattern, then busrq_n=1, disp_bank=1, busy=0.
- Ack stall: hold busak_n=1 for 20 cen after busrq_n falls. Require no src_rd or buf_we during those cycles and the first read only after ack.
- Mid-transfer stall: deassert busak_n for 5 cen at byte 100. Require the strobe gap, no skipped or duplicated addresses, and a byte-exact final buffer.
- Queued requests: three dma_go edges during a busy transfer. Require exactly one extra transfer, writing to bank 0x000..0x1FF, with disp_bank ending at 0.
- Reset mid-transfer: assert rst at byte 300. Require busrq_n=1 and busy=0 in the same cycle and disp_bank=0; a subsequent dma_go still completes a full transfer.
- With JTPANG_DMA_VBLSYNC_EN: finish a transfer with LVBL=1. Require disp_bank unchanged and busy=1 until LVBL falls, then disp_bank toggles within 1 cen.
